// File: rtl/deserializer_pkg.sv
// Shared link definitions for the serializer/deserializer pair:
// FSM state encoding, default word width and counter sizing.
package deserializer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic int counter_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel converter: collects DATA_WIDTH bits LSB first,
// pulses DES_VLD on completion and DES_ERR when a word is cut short.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int COUNTER_WIDTH = counter_width(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DES_IN,
    input  logic                  DES_EN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DES_VLD,
    output logic                  DES_ERR,
    output logic                  DES_BUSY
);

    localparam logic [COUNTER_WIDTH-1:0] LAST =
        COUNTER_WIDTH'(DATA_WIDTH - 1);

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [DATA_WIDTH-1:0]    data_d;
    logic [DATA_WIDTH-1:0]    word;
    logic                     vld_d, err_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
            P_DATA  <= '0;
            DES_VLD <= 1'b0;
            DES_ERR <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            P_DATA  <= data_d;
            DES_VLD <= vld_d;
            DES_ERR <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        data_d  = P_DATA;
        vld_d   = 1'b0;
        err_d   = 1'b0;

        // Insert the incoming bit at the current count position; this also
        // yields the completed word when the count sits on the last bit.
        word = shift_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (count_q == COUNTER_WIDTH'(i)) begin
                word[i] = DES_IN;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (DES_EN) begin
                    if (count_q == LAST) begin
                        data_d  = word;
                        vld_d   = 1'b1;
                        shift_d = '0;
                    end else begin
                        shift_d = word;
                        count_d = count_q + COUNTER_WIDTH'(1);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (DES_EN) begin
                    if (count_q == LAST) begin
                        data_d  = word;
                        vld_d   = 1'b1;
                        shift_d = '0;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        shift_d = word;
                        count_d = count_q + COUNTER_WIDTH'(1);
                    end
                end else begin
                    err_d   = 1'b1;
                    shift_d = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                shift_d = '0;
            end
        endcase
    end

    assign DES_BUSY = (count_q != '0);

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: 8-bit and 1-bit builds driven together,
// checked against a bit-queue reference model of the link protocol.
module tb_deserializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       DES_IN;
    logic       DES_EN;
    logic [7:0] p_data8;
    logic       vld8, err8, busy8;
    logic [0:0] p_data1;
    logic       vld1, err1, busy1;

    int vectors = 0;
    int miscompares = 0;

    bit         q[$];
    logic [7:0] exp_data8;
    logic       exp_vld8, exp_err8;
    logic       exp_data1, exp_vld1;

    always #5 CLK = ~CLK;

    deserializer #(.DATA_WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .DES_IN(DES_IN), .DES_EN(DES_EN),
        .P_DATA(p_data8), .DES_VLD(vld8), .DES_ERR(err8),
        .DES_BUSY(busy8)
    );

    deserializer #(.DATA_WIDTH(1)) dut1 (
        .CLK(CLK), .RST(RST), .DES_IN(DES_IN), .DES_EN(DES_EN),
        .P_DATA(p_data1), .DES_VLD(vld1), .DES_ERR(err1),
        .DES_BUSY(busy1)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, " p_data8"}, p_data8, exp_data8);
        chk({ph, " vld8"}, 8'(vld8), 8'(exp_vld8));
        chk({ph, " err8"}, 8'(err8), 8'(exp_err8));
        chk({ph, " busy8"}, 8'(busy8), 8'(q.size() != 0));
        chk({ph, " p_data1"}, 8'(p_data1), 8'(exp_data1));
        chk({ph, " vld1"}, 8'(vld1), 8'(exp_vld1));
        chk({ph, " err1"}, 8'(err1), 8'h00);
        chk({ph, " busy1"}, 8'(busy1), 8'h00);
    endtask

    // One clock: drive, clock, advance the model, compare.
    task automatic step(input string ph, input logic en, input logic b);
        logic [7:0] w;
        DES_EN = en;
        DES_IN = b;
        @(posedge CLK);
        #1;
        exp_vld8 = 1'b0;
        exp_err8 = 1'b0;
        exp_vld1 = en;
        if (en) begin
            exp_data1 = b;
            q.push_back(b);
            if (q.size() == 8) begin
                w = '0;
                for (int i = 0; i < 8; i++) w = w | (8'(q[i]) << i);
                exp_data8 = w;
                exp_vld8  = 1'b1;
                q.delete();
            end
        end else if (q.size() != 0) begin
            exp_err8 = 1'b1;
            q.delete();
        end
        check_all(ph);
    endtask

    task automatic send_word(input string ph, input logic [7:0] w);
        for (int i = 0; i < 8; i++) step(ph, 1'b1, w[i]);
    endtask

    initial begin
        RST = 1'b0;
        DES_EN = 1'b0;
        DES_IN = 1'b0;
        exp_data8 = '0;
        exp_vld8 = 1'b0;
        exp_err8 = 1'b0;
        exp_data1 = 1'b0;
        exp_vld1 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        RST = 1'b1;

        step("idle", 1'b0, 1'b1);
        send_word("a5", 8'hA5);
        step("a5_after", 1'b0, 1'b0);

        send_word("3c", 8'h3C);
        send_word("c3", 8'hC3);
        step("c3_after", 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("part", 1'b1, 1'(i));
        step("abort", 1'b0, 1'b0);
        step("abort_after", 1'b0, 1'b0);
        send_word("0f", 8'h0F);

        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'(i));
        RST = 1'b0;
        #1;
        q.delete();
        exp_data8 = '0;
        exp_vld8 = 1'b0;
        exp_err8 = 1'b0;
        exp_data1 = 1'b0;
        exp_vld1 = 1'b0;
        check_all("async_rst");
        #2 RST = 1'b1;
        step("rst_after", 1'b0, 1'b0);
        send_word("81", 8'h81);

        // Serializer loopback: enable arrives one cycle late, gated by done.
        step("lb_lead", 1'b0, 1'b0);
        send_word("lb_5a", 8'h5A);
        repeat (3) step("lb_tail", 1'b0, 1'b0);

        step("w1_a", 1'b1, 1'b1);
        step("w1_b", 1'b1, 1'b0);
        step("w1_c", 1'b1, 1'b1);
        step("w1_end", 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 9) != 0), 1'($urandom));
        end
        for (int i = 0; i < 6; i++) send_word("rand_w", 8'($urandom));
        step("end", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
